// File: rtl/dual_issue_pair_stage_pkg.sv
// Shared types and constants for the dual-issue pair stage.
package dual_issue_pair_stage_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // opcode[6:2] encodings of the base integer ISA
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_IMM    = 5'b00100;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [4:0]        op_code;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              rd_we;
    logic              rs1_used;
    logic              rs2_used;
  } lane_t;

  // EMPTY: nothing held; FULL: pair held, nothing issued; SECOND: lane 1 pending
  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FULL   = 2'd1,
    SECOND = 2'd2
  } state_t;

  function automatic logic is_mem(input logic [4:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic logic is_ctrl(input logic [4:0] op);
    return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/dual_issue_pair_stage_hazard.sv
// Intra-pair conflict detection; only a full pair (both lanes valid) can conflict.
module pair_hazard_check
  import dual_issue_pair_stage_pkg::*;
(
  input  lane_t       lane0,
  input  lane_t       lane1,
  input  logic [1:0]  in_valid,
  output logic        hazard
);

  logic raw, waw, mem, ctrl;
  logic unused_lane_bits;

  // pc/imm and most lane-0 source fields never matter for ordering
  assign unused_lane_bits = ^{lane0, lane1};

  // RAW/WAW against lane 0's destination, shared memory port, lane-0 control transfer
  always_comb begin
    raw  = lane0.rd_we && (lane0.rd != '0) &&
           ((lane1.rs1_used && (lane1.rs1 == lane0.rd)) ||
            (lane1.rs2_used && (lane1.rs2 == lane0.rd)));
    waw  = lane0.rd_we && lane1.rd_we && (lane0.rd != '0) && (lane0.rd == lane1.rd);
    mem  = is_mem(lane0.op_code) && is_mem(lane1.op_code);
    ctrl = is_ctrl(lane0.op_code);
    hazard = (in_valid == 2'b11) && (raw || waw || mem || ctrl);
  end

endmodule

// File: rtl/dual_issue_pair_stage.sv
// Registers a decoded instruction pair and issues it to execute, splitting
// conflicting pairs so lane 0 issues one cycle ahead of lane 1.
// Handshake: a side transfers on a rising edge where its valid and ready are
// both high; an offered ex_valid with ex_valid payload holds stable until ex_ready.
module dual_issue_pair_stage
  import dual_issue_pair_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [1:0]             in_valid,
  output logic                   in_ready,
  input  logic [1:0][XLEN-1:0]   in_pc,
  input  logic [1:0][4:0]        in_op_code,
  input  logic [1:0][XLEN-1:0]   in_imm,
  input  logic [1:0][REG_AW-1:0] in_rd,
  input  logic [1:0][REG_AW-1:0] in_rs1,
  input  logic [1:0][REG_AW-1:0] in_rs2,
  input  logic [1:0]             in_rd_we,
  input  logic [1:0]             in_rs1_used,
  input  logic [1:0]             in_rs2_used,
  output logic [1:0]             ex_valid,
  input  logic                   ex_ready,
  output logic [1:0][XLEN-1:0]   ex_pc,
  output logic [1:0][4:0]        ex_op_code,
  output logic [1:0][XLEN-1:0]   ex_imm,
  output logic [1:0][REG_AW-1:0] ex_rd,
  output logic [1:0][REG_AW-1:0] ex_rs1,
  output logic [1:0][REG_AW-1:0] ex_rs2,
  output logic [1:0]             ex_rd_we,
  output logic [1:0]             ex_rs1_used,
  output logic [1:0]             ex_rs2_used
);

  state_t     state_q, state_d;
  logic [1:0] valid_q;
  logic       hazard_q;
  logic       hazard;
  logic       accept;
  logic       load;
  lane_t      in_lane [2];
  lane_t      lane_q  [2];

  // Pack the per-lane input fields into lane structs
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      in_lane[i].pc       = in_pc[i];
      in_lane[i].op_code  = in_op_code[i];
      in_lane[i].imm      = in_imm[i];
      in_lane[i].rd       = in_rd[i];
      in_lane[i].rs1      = in_rs1[i];
      in_lane[i].rs2      = in_rs2[i];
      in_lane[i].rd_we    = in_rd_we[i];
      in_lane[i].rs1_used = in_rs1_used[i];
      in_lane[i].rs2_used = in_rs2_used[i];
    end
  end

  pair_hazard_check u_hazard (
    .lane0    (in_lane[0]),
    .lane1    (in_lane[1]),
    .in_valid (in_valid),
    .hazard   (hazard)
  );

  assign in_ready = (state_q == EMPTY) ||
                    (ex_ready && ((state_q == SECOND) || ((state_q == FULL) && !hazard_q)));
  assign accept   = in_ready && (|in_valid) && !flush;

  // Next-state and capture decision; flush overrides everything
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = FULL;
            load    = 1'b1;
          end
        end
        FULL: begin
          if (ex_ready) begin
            if (hazard_q) begin
              state_d = SECOND;
            end else if (accept) begin
              state_d = FULL;
              load    = 1'b1;
            end else begin
              state_d = EMPTY;
            end
          end
        end
        SECOND: begin
          if (ex_ready) begin
            if (accept) begin
              state_d = FULL;
              load    = 1'b1;
            end else begin
              state_d = EMPTY;
            end
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State, held pair and its conflict flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      valid_q   <= 2'b00;
      hazard_q  <= 1'b0;
      lane_q[0] <= '0;
      lane_q[1] <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        valid_q   <= in_valid;
        hazard_q  <= hazard;
        lane_q[0] <= in_lane[0];
        lane_q[1] <= in_lane[1];
      end
    end
  end

  // Issue mask: split pairs show lane 0 first, then lane 1 in its own slot
  always_comb begin
    ex_valid = 2'b00;
    case (state_q)
      FULL:    ex_valid = hazard_q ? 2'b01 : valid_q;
      SECOND:  ex_valid = 2'b10;
      default: ex_valid = 2'b00;
    endcase
  end

  // Unpack held lanes onto the execute-side fields
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ex_pc[i]       = lane_q[i].pc;
      ex_op_code[i]  = lane_q[i].op_code;
      ex_imm[i]      = lane_q[i].imm;
      ex_rd[i]       = lane_q[i].rd;
      ex_rs1[i]      = lane_q[i].rs1;
      ex_rs2[i]      = lane_q[i].rs2;
      ex_rd_we[i]    = lane_q[i].rd_we;
      ex_rs1_used[i] = lane_q[i].rs1_used;
      ex_rs2_used[i] = lane_q[i].rs2_used;
    end
  end

endmodule

// File: tb/tb_dual_issue_pair_stage.sv
// Directed bench for the dual-issue pair stage.
module tb_dual_issue_pair_stage;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [1:0]       in_valid;
  logic             in_ready;
  logic [1:0][31:0] in_pc, in_imm;
  logic [1:0][4:0]  in_op_code, in_rd, in_rs1, in_rs2;
  logic [1:0]       in_rd_we, in_rs1_used, in_rs2_used;
  logic [1:0]       ex_valid;
  logic             ex_ready;
  logic [1:0][31:0] ex_pc, ex_imm;
  logic [1:0][4:0]  ex_op_code, ex_rd, ex_rs1, ex_rs2;
  logic [1:0]       ex_rd_we, ex_rs1_used, ex_rs2_used;

  int errors = 0;
  int checks = 0;

  dual_issue_pair_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_op_code  (in_op_code),
    .in_imm      (in_imm),
    .in_rd       (in_rd),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_rd_we    (in_rd_we),
    .in_rs1_used (in_rs1_used),
    .in_rs2_used (in_rs2_used),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_pc       (ex_pc),
    .ex_op_code  (ex_op_code),
    .ex_imm      (ex_imm),
    .ex_rd       (ex_rd),
    .ex_rs1      (ex_rs1),
    .ex_rs2      (ex_rs2),
    .ex_rd_we    (ex_rd_we),
    .ex_rs1_used (ex_rs1_used),
    .ex_rs2_used (ex_rs2_used)
  );

  // clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // advance past the next rising edge, leaving outputs settled
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input logic [31:0] pc, input logic [4:0] op,
                          input logic [31:0] imm, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic we, input logic u1, input logic u2);
    in_pc[l]       = pc;
    in_op_code[l]  = op;
    in_imm[l]      = imm;
    in_rd[l]       = rd;
    in_rs1[l]      = rs1;
    in_rs2[l]      = rs2;
    in_rd_we[l]    = we;
    in_rs1_used[l] = u1;
    in_rs2_used[l] = u2;
  endtask

  task automatic idle_inputs();
    in_valid = 2'b00;
    flush    = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    in_valid = 2'b00;
    ex_ready = 1'b1;
    in_pc = '0; in_imm = '0; in_op_code = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_rd_we = '0; in_rs1_used = '0; in_rs2_used = '0;
    #2;
    check("rst_ex_valid", ex_valid, 2'b00);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_ex_imm",   ex_imm, 64'd0);
    check("rst_ex_pc",    ex_pc,  64'd0);
    #10 rst_n = 1'b1;
    tick();

    // addi x5,x0,1 | addi x6,x0,2 : dual issue
    set_lane(0, 32'h100, 5'b00100, 32'd1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    set_lane(1, 32'h104, 5'b00100, 32'd2, 5'd6, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    in_valid = 2'b11; ex_ready = 1'b1;
    #1 check("t1_in_ready_pre", in_ready, 1'b1);
    tick();
    idle_inputs();
    #1;
    check("t1_ex_valid", ex_valid, 2'b11);
    check("t1_imm0",     ex_imm[0], 32'd1);
    check("t1_imm1",     ex_imm[1], 32'd2);
    check("t1_pc1",      ex_pc[1], 32'h104);
    check("t1_in_ready", in_ready, 1'b1);
    tick();
    check("t1_drain", ex_valid, 2'b00);

    // addi x5 | add x7,x5,x1 : RAW split
    set_lane(0, 32'h200, 5'b00100, 32'd1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    set_lane(1, 32'h204, 5'b01100, 32'd0, 5'd7, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1);
    in_valid = 2'b11;
    tick();
    idle_inputs();
    #1;
    check("raw_first",    ex_valid, 2'b01);
    check("raw_in_ready", in_ready, 1'b0);
    tick();
    check("raw_second",    ex_valid, 2'b10);
    check("raw_rd1",       ex_rd[1], 5'd7);
    check("raw_in_ready2", in_ready, 1'b1);
    tick();
    check("raw_drain", ex_valid, 2'b00);

    // addi x5 | addi x5 : WAW split
    set_lane(0, 32'h280, 5'b00100, 32'd3, 5'd5, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    set_lane(1, 32'h284, 5'b00100, 32'd4, 5'd5, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    in_valid = 2'b11;
    tick();
    idle_inputs();
    check("waw_first", ex_valid, 2'b01);
    tick();
    check("waw_second", ex_valid, 2'b10);
    tick();

    // lw x1 | sw x2 : MEM split with execute stalled for 3 cycles
    set_lane(0, 32'h300, 5'b00000, 32'd4, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0);
    set_lane(1, 32'h304, 5'b01000, 32'd8, 5'd0, 5'd3, 5'd2, 1'b0, 1'b1, 1'b1);
    in_valid = 2'b11; ex_ready = 1'b0;
    tick();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      check("mem_hold_valid", ex_valid, 2'b01);
      check("mem_hold_imm0",  ex_imm[0], 32'd4);
      check("mem_hold_ready", in_ready, 1'b0);
      tick();
    end
    check("mem_hold_after", ex_valid, 2'b01);
    ex_ready = 1'b1;
    tick();
    check("mem_second", ex_valid, 2'b10);
    check("mem_imm1",   ex_imm[1], 32'd8);
    tick();
    check("mem_drain", ex_valid, 2'b00);

    // beq (imm -16) | addi x9 : CTRL split, flush while lane 1 pending
    set_lane(0, 32'h400, 5'b11000, 32'hFFFF_FFF0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1);
    set_lane(1, 32'h404, 5'b00100, 32'd9, 5'd9, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    in_valid = 2'b11;
    tick();
    idle_inputs();
    check("ctrl_first", ex_valid, 2'b01);
    check("ctrl_imm0",  ex_imm[0], 32'hFFFF_FFF0);
    tick();
    check("ctrl_second", ex_valid, 2'b10);
    flush = 1'b1; ex_ready = 1'b0;
    tick();
    flush = 1'b0; ex_ready = 1'b1;
    #1;
    check("ctrl_flushed", ex_valid, 2'b00);
    check("ctrl_ready",   in_ready, 1'b1);
    tick();
    check("ctrl_stays_empty", ex_valid, 2'b00);

    // addi x0 | add x3,x0,x0 : rd=x0 never conflicts
    set_lane(0, 32'h500, 5'b00100, 32'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    set_lane(1, 32'h504, 5'b01100, 32'd0, 5'd3, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
    in_valid = 2'b11;
    tick();
    check("x0_dual", ex_valid, 2'b11);
    // back-to-back: lane 1 alone, stale lane 0 is a branch that must not split it
    set_lane(0, 32'h600, 5'b11000, 32'd0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1);
    set_lane(1, 32'h604, 5'b00100, 32'd7, 5'd4, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    in_valid = 2'b10;
    #1 check("b2b_in_ready", in_ready, 1'b1);
    tick();
    idle_inputs();
    check("lane1_only", ex_valid, 2'b10);
    check("lane1_imm",  ex_imm[1], 32'd7);
    check("lane1_pc",   ex_pc[1], 32'h604);
    tick();
    check("lane1_drain", ex_valid, 2'b00);

    // asynchronous reset while FULL
    set_lane(0, 32'h700, 5'b00100, 32'd5, 5'd10, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    set_lane(1, 32'h704, 5'b00100, 32'd6, 5'd11, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    in_valid = 2'b11; ex_ready = 1'b0;
    tick();
    idle_inputs();
    check("prerst_full", ex_valid, 2'b11);
    rst_n = 1'b0;
    #1;
    check("arst_ex_valid", ex_valid, 2'b00);
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_pc0",      ex_pc[0], 32'd0);
    #1 rst_n = 1'b1;
    ex_ready = 1'b1;

    // flush with a simultaneous pair offer: nothing captured
    in_valid = 2'b11; flush = 1'b1;
    tick();
    idle_inputs();
    check("flush_accept_valid", ex_valid, 2'b00);
    check("flush_accept_ready", in_ready, 1'b1);
    check("flush_accept_imm0",  ex_imm[0], 32'd0);
    tick();
    check("flush_accept_later", ex_valid, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
